// File: rtl/s298_response_misr.sv
`default_nettype none
// ============================================================================
// Module   : s298_response_misr
// Purpose  : Folds the s298 core's six outputs into a 16-bit MISR over a
//            programmable window. Optional golden compare: S298_MISR_COMPARE_EN
// Revision : 1.0  initial release
// ============================================================================
module s298_response_misr #(
  parameter int               DATA_W = 6,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int               CNT_W  = 16,
  parameter int               WARMUP = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  window_len,
  input  logic [DATA_W-1:0] resp_in,
  input  logic              resp_valid,
`ifdef S298_MISR_COMPARE_EN
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              pass,
  output logic              fail,
`endif
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [SIG_W-1:0]  sig_next;
  logic [SIG_W-1:0]  misr_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  len_q, len_next;
  logic [WU_W-1:0]   warm_cnt, warm_next;

  // Shift left, fold the outgoing MSB back through the taps, then inject the sample.
  assign misr_next = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(resp_in);
  assign cnt_inc   = sample_count + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      signature    <= SEED;
      sample_count <= '0;
      len_q        <= '0;
      warm_cnt     <= '0;
    end else begin
      state        <= state_next;
      signature    <= sig_next;
      sample_count <= cnt_next;
      len_q        <= len_next;
      warm_cnt     <= warm_next;
    end
  end

  always_comb begin
    state_next = state;
    sig_next   = signature;
    cnt_next   = sample_count;
    len_next   = len_q;
    warm_next  = warm_cnt;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          state_next = ST_SKIP;
          len_next   = window_len;
          sig_next   = SEED;
          cnt_next   = '0;
          warm_next  = '0;
        end
      end
      ST_SKIP: begin
        busy      = 1'b1;
        warm_next = warm_cnt + WU_W'(1);
        if (warm_cnt == WU_LAST) begin
          state_next = (len_q == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (resp_valid) begin
          sig_next = misr_next;
          cnt_next = cnt_inc;
          if (cnt_inc == len_q) begin
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef S298_MISR_COMPARE_EN
  // Verdict appears from the second DONE cycle onward; a restart clears it at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state == ST_DONE && !start) begin
      pass <= (signature == golden_sig);
      fail <= (signature != golden_sig);
    end else begin
      pass <= 1'b0;
      fail <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/s298_response_misr.md
Name: s298_response_misr

Overview:
- Downstream response compactor for the s298 sequential benchmark core.
- Consumes the core's six primary outputs every clock and folds them into a multiple-input signature register (MISR) over a programmable capture window.
- Exposes the final signature for comparison against a golden value, so long benchmark runs reduce to one word on the FPGA test fabric.
- Sits directly after s298 on the same clock domain.

Parameters:
- DATA_W, 6, width of resp_in; LSB-first packing order is G67,G133,G118,G66,G132,G117.
- SIG_W, 16, signature width; must be >= DATA_W.
- POLY, 16'h1021, feedback taps (x^16+x^12+x^5+1), applied when the shifted-out MSB is 1.
- SEED, 16'h0000, value loaded into the signature on start.
- CNT_W, 16, width of window_len and sample_count.
- WARMUP, 2, cycles discarded after start to let the core's state flush; 0 is legal.

Ports:
- clock  input  1  single rising-edge clock, shared with s298.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that arms a capture run.
- window_len  input  CNT_W  number of valid samples to compact; sampled on the start edge.
- resp_in  input  DATA_W  s298 outputs, packed per DATA_W.
- resp_valid  input  1  resp_in qualifier; samples with resp_valid low are ignored.
- busy  output  1  high in SKIP and CAPTURE.
- done  output  1  high in DONE; sticky.
- signature  output  SIG_W  current MISR contents.
- sample_count  output  CNT_W  valid samples compacted in the current run.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, signature=SEED, sample_count=0, warmup counter=0. Reset takes priority over all other inputs, including mid-run; the run is aborted.
- States:
  - IDLE: start -> SKIP. Latch window_len, load signature=SEED, clear sample_count and the warmup counter.
  - SKIP: the warmup counter increments every cycle regardless of resp_valid. When the counter equals WARMUP, go to CAPTURE, or to DONE if the latched window_len==0.
  - WARMUP=0: SKIP lasts exactly 1 cycle, which is allowed.
  - CAPTURE: on each edge with resp_valid=1, update the signature and increment sample_count. When sample_count+1 equals the latched window_len on a valid edge, go to DONE on that same edge. resp_valid=0 holds signature and count unchanged.
  - DONE: done=1, busy=0, signature and sample_count frozen. start -> SKIP, reinitialised exactly as from IDLE.
- start is ignored in SKIP and CAPTURE; it never restarts or extends a run.
- A later change to window_len after the start edge has no effect.
- MISR update: sig_next = (sig<<1, LSB 0) XOR (sig[SIG_W-1] ? POLY : 0) XOR zero-extend(resp_in).
- Latency: signature reflects a sample one cycle after the edge that captured it. done rises on the edge that captures the last sample, so the final signature and done are visible together.
- sample_count does not wrap: window_len <= 2^CNT_W-1 bounds it.

Optional Feature:
- Macro: S298_MISR_COMPARE_EN.
- When defined:
  - Adds input golden_sig [SIG_W] and outputs pass [1] and fail [1].
  - On entry to DONE, registered one cycle later: pass=(signature==golden_sig), fail=~pass.
  - Both are 0 outside DONE and in the first DONE cycle; both clear on reset or start.
- When undefined: none of these ports or logic exist, and the remaining behaviour is identical.

Test Plan:
- Reset: assert reset 1 cycle during CAPTURE with WARMUP=2 -> next cycle busy=0, done=0, signature=16'h0000, sample_count=0; a subsequent start behaves normally.
- Single sample: SEED=0, window_len=1, after warmup resp_in=6'h2A with valid -> done=1 and signature=16'h002A on the same cycle; sample_count=1.
- Two samples: window_len=2, resp_in=6'h01 twice -> signature=16'h0003, done after the second valid edge.
- Feedback: SEED=16'h8000, window_len=1, resp_in=0 -> signature=16'h1021.
- Gaps and ignored start: window_len=3 with valid pattern 1,0,1,0,1 and a start pulse mid-run -> done after the 5th capture cycle, sample_count=3, no restart.
- window_len=0 -> done after WARMUP+1 cycles, signature=SEED. With S298_MISR_COMPARE_EN and golden_sig=SEED -> pass=1 one cycle later; golden_sig=SEED^1 -> fail=1.
